// File: rtl/m_mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the memory access unit: op codes,
//               FSM state encoding, lane/offset width helpers and the op
//               decoder (op -> access size, load flag, signedness).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8,
    OP_LD   = 4'd9,
    OP_SD   = 4'd10
  } mem_op_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;      // op performs an access on this data width
    logic [3:0] bytes;      // access size in bytes (1/2/4/8)
    logic       is_load;
    logic       is_signed;  // sign-extend load data
  } op_info_t;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Unknown codes and doubleword ops on a 32-bit path decode to "no access".
  function automatic op_info_t decode_op(input logic [3:0] op, input int data_w);
    op_info_t info;
    info = '0;
    case (op)
      OP_LW:  begin info.bytes = 4'd4; info.is_load = 1'b1; info.is_signed = 1'b1; end
      OP_LH:  begin info.bytes = 4'd2; info.is_load = 1'b1; info.is_signed = 1'b1; end
      OP_LHU: begin info.bytes = 4'd2; info.is_load = 1'b1; end
      OP_LB:  begin info.bytes = 4'd1; info.is_load = 1'b1; info.is_signed = 1'b1; end
      OP_LBU: begin info.bytes = 4'd1; info.is_load = 1'b1; end
      OP_SW:  info.bytes = 4'd4;
      OP_SH:  info.bytes = 4'd2;
      OP_SB:  info.bytes = 4'd1;
      OP_LD:  if (data_w == 64) begin info.bytes = 4'd8; info.is_load = 1'b1; end
      OP_SD:  if (data_w == 64) info.bytes = 4'd8;
      default: ;
    endcase
    info.valid = (info.bytes != 4'd0);
    return info;
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_mem_access_unit_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Purely combinational byte-lane steering.
//               Store side: replicates the low byte/half/word of the store
//               data across all lanes and builds the lane enable mask.
//               Load side: extracts the addressed lane from bus read data and
//               sign- or zero-extends it to DATA_W.
// Ports       : i_st_bytes/i_st_off/i_wdata -> o_byteen, o_wdata_rep
//               i_ld_bytes/i_ld_off/i_ld_signed/i_rdata -> o_rdata_ext
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]                      i_st_bytes,
  input  logic [off_bits(DATA_W)-1:0]     i_st_off,
  input  logic [DATA_W-1:0]               i_wdata,
  output logic [lanes(DATA_W)-1:0]        o_byteen,
  output logic [DATA_W-1:0]               o_wdata_rep,
  input  logic [3:0]                      i_ld_bytes,
  input  logic [off_bits(DATA_W)-1:0]     i_ld_off,
  input  logic                            i_ld_signed,
  input  logic [DATA_W-1:0]               i_rdata,
  output logic [DATA_W-1:0]               o_rdata_ext
);

  localparam int NB = lanes(DATA_W);

  logic [NB-1:0]     w_mask;
  logic [DATA_W-1:0] w_shift;

  always_comb begin
    w_mask      = '0;
    o_wdata_rep = '0;
    case (i_st_bytes)
      4'd1: begin w_mask = NB'(1);  o_wdata_rep = {NB{i_wdata[7:0]}};        end
      4'd2: begin w_mask = NB'(3);  o_wdata_rep = {(NB/2){i_wdata[15:0]}};   end
      4'd4: begin w_mask = NB'(15); o_wdata_rep = {(NB/4){i_wdata[31:0]}};   end
      4'd8: begin w_mask = '1;      o_wdata_rep = i_wdata;                   end
      default: ;
    endcase
    o_byteen = w_mask << i_st_off;
  end

  // Bring the addressed lane down to bit 0, then extend; the signed casts
  // make the width cast replicate the lane's top bit.
  always_comb begin
    w_shift     = i_rdata >> {i_ld_off, 3'b000};
    o_rdata_ext = '0;
    case (i_ld_bytes)
      4'd1: o_rdata_ext = i_ld_signed ? DATA_W'($signed(w_shift[7:0]))
                                      : DATA_W'(w_shift[7:0]);
      4'd2: o_rdata_ext = i_ld_signed ? DATA_W'($signed(w_shift[15:0]))
                                      : DATA_W'(w_shift[15:0]);
      4'd4: o_rdata_ext = i_ld_signed ? DATA_W'($signed(w_shift[31:0]))
                                      : DATA_W'(w_shift[31:0]);
      4'd8: o_rdata_ext = w_shift;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/m_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : m_mem_access_unit
// Description : M-stage memory access unit. Accepts a memory op from the M
//               pipeline register, checks alignment, runs a req/ack bus cycle
//               with pipeline stall and timeout, and returns extended load
//               data (or an exception) as a one-cycle pulse aligned to W.
// Ports       : clk, reset                 - clock, sync active-high reset
//               in_valid/in_op/in_addr/in_wdata - M-stage request
//               stall                      - freeze F/D/E/M
//               bus_req/we/addr/byteen/wdata, bus_ack/rdata - data bus
//               out_valid/out_rdata, exc_adel/exc_ades/exc_bus - W-stage result
// Revision    : 1.0 - initial release
// ============================================================================
module m_mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [3:0]             in_op,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [DATA_W-1:0]      in_wdata,
  output logic                   stall,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [DATA_W/8-1:0]    bus_byteen,
  output logic [DATA_W-1:0]      bus_wdata,
  input  logic                   bus_ack,
  input  logic [DATA_W-1:0]      bus_rdata,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_rdata,
  output logic                   exc_adel,
  output logic                   exc_ades,
  output logic                   exc_bus
);

  localparam int NB    = lanes(DATA_W);
  localparam int OFF_W = off_bits(DATA_W);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [NB-1:0]         bus_byteen_q, bus_byteen_d;
  logic [DATA_W-1:0]     bus_wdata_q, bus_wdata_d;
  logic [3:0]            ld_bytes_q, ld_bytes_d;
  logic [OFF_W-1:0]      ld_off_q, ld_off_d;
  logic                  ld_signed_q, ld_signed_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_rdata_q, out_rdata_d;
  logic                  exc_adel_q, exc_adel_d;
  logic                  exc_ades_q, exc_ades_d;
  logic                  exc_bus_q, exc_bus_d;

  op_info_t              w_info;
  logic                  w_misaligned;
  logic                  w_timeout;
  logic [NB-1:0]         w_byteen;
  logic [DATA_W-1:0]     w_wdata_rep;
  logic [DATA_W-1:0]     w_rdata_ext;

  assign w_info = decode_op(in_op, DATA_W);
  // bytes-1 masks exactly the address bits that must be zero; for 8 bytes
  // the 3-bit subtraction wraps to 3'b111.
  assign w_misaligned = |(in_addr[2:0] & (w_info.bytes[2:0] - 3'd1));
  assign w_timeout    = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .i_st_bytes  (w_info.bytes),
    .i_st_off    (in_addr[OFF_W-1:0]),
    .i_wdata     (in_wdata),
    .o_byteen    (w_byteen),
    .o_wdata_rep (w_wdata_rep),
    .i_ld_bytes  (ld_bytes_q),
    .i_ld_off    (ld_off_q),
    .i_ld_signed (ld_signed_q),
    .i_rdata     (bus_rdata),
    .o_rdata_ext (w_rdata_ext)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_byteen_d = bus_byteen_q;
    bus_wdata_d  = bus_wdata_q;
    ld_bytes_d   = ld_bytes_q;
    ld_off_d     = ld_off_q;
    ld_signed_d  = ld_signed_q;
    out_valid_d  = 1'b0;
    out_rdata_d  = '0;
    exc_adel_d   = 1'b0;
    exc_ades_d   = 1'b0;
    exc_bus_d    = 1'b0;
    stall        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && w_info.valid) begin
          if (w_misaligned) begin
            // Exception is reported without touching the bus or stalling.
            out_valid_d = 1'b1;
            exc_adel_d  = w_info.is_load;
            exc_ades_d  = !w_info.is_load;
          end else begin
            stall        = 1'b1;
            state_d      = ST_BUSY;
            cnt_d        = CNT_W'(1);
            bus_req_d    = 1'b1;
            bus_we_d     = !w_info.is_load;
            bus_addr_d   = in_addr & ~ADDR_W'(NB - 1);
            bus_byteen_d = w_info.is_load ? '0 : w_byteen;
            bus_wdata_d  = w_info.is_load ? '0 : w_wdata_rep;
            ld_bytes_d   = w_info.bytes;
            ld_off_d     = in_addr[OFF_W-1:0];
            ld_signed_d  = w_info.is_signed;
          end
        end
      end
      ST_BUSY: begin
        if (bus_ack || w_timeout) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          bus_req_d    = 1'b0;
          bus_we_d     = 1'b0;
          bus_addr_d   = '0;
          bus_byteen_d = '0;
          bus_wdata_d  = '0;
          out_valid_d  = 1'b1;
          // Ack wins over a coincident timeout. bus_we_q still tells load
          // from store in this final BUSY cycle.
          if (bus_ack) begin
            out_rdata_d = bus_we_q ? '0 : w_rdata_ext;
          end else begin
            exc_bus_d = 1'b1;
          end
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_byteen_q <= '0;
      bus_wdata_q  <= '0;
      ld_bytes_q   <= '0;
      ld_off_q     <= '0;
      ld_signed_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_rdata_q  <= '0;
      exc_adel_q   <= 1'b0;
      exc_ades_q   <= 1'b0;
      exc_bus_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_byteen_q <= bus_byteen_d;
      bus_wdata_q  <= bus_wdata_d;
      ld_bytes_q   <= ld_bytes_d;
      ld_off_q     <= ld_off_d;
      ld_signed_q  <= ld_signed_d;
      out_valid_q  <= out_valid_d;
      out_rdata_q  <= out_rdata_d;
      exc_adel_q   <= exc_adel_d;
      exc_ades_q   <= exc_ades_d;
      exc_bus_q    <= exc_bus_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_byteen = bus_byteen_q;
  assign bus_wdata  = bus_wdata_q;
  assign out_valid  = out_valid_q;
  assign out_rdata  = out_rdata_q;
  assign exc_adel   = exc_adel_q;
  assign exc_ades   = exc_ades_q;
  assign exc_bus    = exc_bus_q;

endmodule
`default_nettype wire

// File: tb/tb_m_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_mem_access_unit
// Description : Self-checking bench for m_mem_access_unit. One 32-bit and one
//               64-bit instance (both TIMEOUT=4) share a stimulus bus selected
//               by t_sel; expected W-stage results are queued per instance
//               and matched against each out_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_m_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        t_sel, t_valid, t_ack;
  logic [3:0]  t_op;
  logic [31:0] t_addr;
  logic [63:0] t_wd, t_rd;

  logic        stall32, req32, we32, ov32, adel32, ades32, bx32;
  logic [31:0] addr32, wd32, ord32;
  logic [3:0]  be32;
  logic        stall64, req64, we64, ov64, adel64, ades64, bx64;
  logic [31:0] addr64;
  logic [63:0] wd64, ord64;
  logic [7:0]  be64;

  m_mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(t_valid & ~t_sel), .in_op(t_op), .in_addr(t_addr), .in_wdata(t_wd[31:0]),
    .stall(stall32), .bus_req(req32), .bus_we(we32), .bus_addr(addr32),
    .bus_byteen(be32), .bus_wdata(wd32),
    .bus_ack(t_ack & ~t_sel), .bus_rdata(t_rd[31:0]),
    .out_valid(ov32), .out_rdata(ord32),
    .exc_adel(adel32), .exc_ades(ades32), .exc_bus(bx32)
  );

  m_mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(t_valid & t_sel), .in_op(t_op), .in_addr(t_addr), .in_wdata(t_wd),
    .stall(stall64), .bus_req(req64), .bus_we(we64), .bus_addr(addr64),
    .bus_byteen(be64), .bus_wdata(wd64),
    .bus_ack(t_ack & t_sel), .bus_rdata(t_rd),
    .out_valid(ov64), .out_rdata(ord64),
    .exc_adel(adel64), .exc_ades(ades64), .exc_bus(bx64)
  );

  logic        w_stall, w_req, w_we;
  logic [31:0] w_addr;
  logic [7:0]  w_be;
  logic [63:0] w_wd;
  assign w_stall = t_sel ? stall64 : stall32;
  assign w_req   = t_sel ? req64   : req32;
  assign w_we    = t_sel ? we64    : we32;
  assign w_addr  = t_sel ? addr64  : addr32;
  assign w_be    = t_sel ? be64    : {4'b0, be32};
  assign w_wd    = t_sel ? wd64    : {32'b0, wd32};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] rdata;
    logic [2:0]  exc;   // {adel, ades, bus}
  } exp_t;

  exp_t sb32[$];
  exp_t sb64[$];

  always @(negedge clk) begin : mon32
    exp_t e;
    if (ov32) begin
      if (sb32.size() == 0) begin
        chk("ov32_unexpected", ov32, 0);
      end else begin
        e = sb32.pop_front();
        chk("rdata32", ord32, e.rdata);
        chk("exc32", {adel32, ades32, bx32}, e.exc);
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (ov64) begin
      if (sb64.size() == 0) begin
        chk("ov64_unexpected", ov64, 0);
      end else begin
        e = sb64.pop_front();
        chk("rdata64", ord64, e.rdata);
        chk("exc64", {adel64, ades64, bx64}, e.exc);
      end
    end
  end

  // Drives one M-stage op and plays the bus slave (ack in BUSY cycle ack_at,
  // 0 = never). Called and returns at posedge+1.
  task automatic run_op(input bit sel, input logic [3:0] op, input logic [31:0] addr,
                        input logic [63:0] wd, input int ack_at, input logic [63:0] rd,
                        input bit has_bus, input logic [31:0] e_addr, input logic [7:0] e_be,
                        input logic [63:0] e_wd, input bit has_out,
                        input logic [63:0] e_rdata, input logic [2:0] e_exc);
    int   k = 0;
    int   stalls = 0;
    int   reqs = 0;
    int   exp_cyc;
    bit   done = 0;
    exp_t e;
    t_sel = sel; t_op = op; t_addr = addr; t_wd = wd; t_rd = rd; t_valid = 1'b1;
    if (has_out) begin
      e.rdata = e_rdata;
      e.exc   = e_exc;
      if (sel) sb64.push_back(e); else sb32.push_back(e);
    end
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      t_ack = 1'b0;
      if (w_req) begin
        k++;
        reqs++;
        if (k == 1) begin
          chk("bus_addr", w_addr, e_addr);
          chk("bus_byteen", w_be, e_be);
          chk("bus_we", w_we, e_be != 0);
          if (e_be != 0) chk("bus_wdata", w_wd, e_wd);
        end
        t_ack = (k == ack_at);
      end
      @(negedge clk);
      if (w_stall) stalls++; else done = 1;
      @(posedge clk);
      #1;
    end
    t_ack = 1'b0; t_valid = 1'b0; t_op = 4'd0;
    if (!done) chk("stall_bound", w_stall, 0);
    exp_cyc = !has_bus ? 0 : ((ack_at > 0) ? ack_at : 4);
    chk("stall_cycles", stalls, exp_cyc);
    chk("req_cycles", reqs, exp_cyc);
    chk("req_clear", w_req, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    reset = 1'b1;
    t_sel = 1'b0; t_valid = 1'b0; t_ack = 1'b0; t_op = 4'd0;
    t_addr = '0; t_wd = '0; t_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl32", {stall32, req32, we32, ov32, adel32, ades32, bx32}, 0);
    chk("rst_bus32", {addr32, be32, wd32[27:0]}, 0);
    chk("rst_ctl64", {stall64, req64, we64, ov64, adel64, ades64, bx64}, 0);
    chk("rst_rd64", ord64, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ---------------- DATA_W = 32 ----------------
    run_op(0, 4'd8, 32'h1003, 64'hAB, 3, 0, 1, 32'h1000, 8'h08, 64'hABABABAB, 1, 0, 3'b000);
    run_op(0, 4'd2, 32'h1002, 0, 1, 64'h80017FFF, 1, 32'h1000, 8'h00, 0, 1, 64'hFFFF8001, 3'b000);
    run_op(0, 4'd3, 32'h1002, 0, 1, 64'h80017FFF, 1, 32'h1000, 8'h00, 0, 1, 64'h00008001, 3'b000);
    run_op(0, 4'd1, 32'h1001, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b100);
    run_op(0, 4'd7, 32'h1001, 64'h1234, 0, 0, 0, 0, 0, 0, 1, 0, 3'b010);
    run_op(0, 4'd6, 32'h1004, 64'h12345678, 0, 0, 1, 32'h1004, 8'h0F, 64'h12345678, 1, 0, 3'b001);
    run_op(0, 4'd6, 32'h1004, 64'h12345678, 4, 0, 1, 32'h1004, 8'h0F, 64'h12345678, 1, 0, 3'b000);
    run_op(0, 4'd4, 32'h1001, 0, 2, 64'h00007F00, 1, 32'h1000, 8'h00, 0, 1, 64'h7F, 3'b000);
    run_op(0, 4'd1, 32'h1008, 0, 1, 64'hDEADBEEF, 1, 32'h1008, 8'h00, 0, 1, 64'hDEADBEEF, 3'b000);
    run_op(0, 4'd9, 32'h1010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    run_op(0, 4'd13, 32'h1010, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    run_op(0, 4'd7, 32'h1002, 64'hBEEF, 1, 0, 1, 32'h1000, 8'h0C, 64'hBEEFBEEF, 1, 0, 3'b000);

    // Reset in the 2nd BUSY cycle abandons the access silently.
    t_sel = 1'b0; t_op = 4'd1; t_addr = 32'h3000; t_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy2_req", req32, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; t_valid = 1'b0; t_op = 4'd0;
    @(negedge clk);
    chk("rst_busy_ctl", {stall32, req32, we32, ov32, adel32, ades32, bx32}, 0);
    chk("rst_busy_addr", addr32, 0);
    @(posedge clk); #1;
    run_op(0, 4'd1, 32'h2000, 0, 2, 64'h00C0FFEE, 1, 32'h2000, 8'h00, 0, 1, 64'h00C0FFEE, 3'b000);

    // ---------------- DATA_W = 64 ----------------
    run_op(1, 4'd10, 32'h8, 64'h0123456789ABCDEF, 1, 0, 1, 32'h8, 8'hFF, 64'h0123456789ABCDEF, 1, 0, 3'b000);
    run_op(1, 4'd4, 32'hF, 0, 1, 64'h8011223344556677, 1, 32'h8, 8'h00, 0, 1, 64'hFFFFFFFFFFFFFF80, 3'b000);
    run_op(1, 4'd9, 32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3'b100);
    run_op(1, 4'd9, 32'h10, 0, 2, 64'hCAFEBABE12345678, 1, 32'h10, 8'h00, 0, 1, 64'hCAFEBABE12345678, 3'b000);
    run_op(1, 4'd1, 32'h14, 0, 1, 64'h8765432100000000, 1, 32'h10, 8'h00, 0, 1, 64'hFFFFFFFF87654321, 3'b000);
    run_op(1, 4'd8, 32'h1B, 64'h5A, 3, 0, 1, 32'h18, 8'h08, 64'h5A5A5A5A5A5A5A5A, 1, 0, 3'b000);
    run_op(1, 4'd3, 32'h1E, 0, 1, 64'hBEEF000000000000, 1, 32'h18, 8'h00, 0, 1, 64'hBEEF, 3'b000);
    run_op(1, 4'd6, 32'h4, 64'h12345678, 1, 0, 1, 32'h0, 8'hF0, 64'h1234567812345678, 1, 0, 3'b000);

    repeat (3) @(posedge clk);
    chk("sb32_drained", sb32.size(), 0);
    chk("sb64_drained", sb64.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/m_mem_access_unit.md
Name: m_mem_access_unit

Overview:
Memory-stage access unit for the pipelined MIPS core. It generalises the M-stage store byte-enable and load-extension logic to a parametrised data width (32/64). It adds a variable-latency req/ack data-bus handshake with pipeline stall, an alignment exception check and a bus timeout. It sits between the M-stage pipeline register and the data bus, and delivers extended load data timed for the W stage.

Parameters:
DATA_W, 32, data path width; only 32 or 64 are legal; NB = DATA_W/8 byte lanes
ADDR_W, 32, address width
TIMEOUT, 15, number of BUSY cycles without ack before the access aborts with a bus error; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  M stage holds a valid instruction; upstream holds all in_* stable while stall=1
in_op  in  4  memory op code (mem_pkg)
in_addr  in  ADDR_W  effective byte address
in_wdata  in  DATA_W  store data, right-justified
stall  out  1  freeze F/D/E/M stages
bus_req  out  1  bus request, held until ack or timeout
bus_we  out  1  write strobe
bus_addr  out  ADDR_W  address aligned to NB bytes
bus_byteen  out  NB  byte-lane enables, writes only
bus_wdata  out  DATA_W  lane-replicated store data
bus_ack  in  1  bus completion, sampled only while bus_req=1
bus_rdata  in  DATA_W  read data, valid with bus_ack
out_valid  out  1  one-cycle completion pulse, aligned with the instruction in W
out_rdata  out  DATA_W  extended load data; 0 for stores and exceptions
exc_adel  out  1  misaligned load, qualified by out_valid
exc_ades  out  1  misaligned store, qualified by out_valid
exc_bus  out  1  timeout abort, qualified by out_valid

Behaviour:
- Reset (sync, high): state IDLE, timeout counter 0; every output is 0 on the next cycle. A pending bus transaction is abandoned with no out_valid pulse.
- Op codes: NONE=0, LW=1, LH=2, LHU=3, LB=4, LBU=5, SW=6, SH=7, SB=8, LD=9, SD=10.
  - Codes 11-15, and LD/SD when DATA_W=32, are treated as NONE: no access, no output.
- Accept: the accept condition is state==IDLE && in_valid && op!=NONE.
- Alignment rule: halfword needs addr[0]==0; word needs addr[1:0]==0; doubleword needs addr[2:0]==0.
- Misaligned access: no bus cycle and stall=0. At the next edge, out_valid=1 with exc_adel (load) or exc_ades (store). out_rdata=0.
- Aligned access:
  - stall=1 combinationally in the accept cycle.
  - At the accept edge, the bus registers load and the state goes to BUSY.
  - bus_addr = addr with the low log2(NB) bits cleared; bus_we=1 for stores.
  - Store lanes: bus_wdata replicates the low byte / half / word of in_wdata across all lanes.
  - bus_byteen sets the NB lanes covered by the access, starting at addr offset. Example: SB at offset 3 -> 0001 shifted 3 = 1000 (DATA_W=32).
- FSM IDLE -> BUSY -> IDLE:
  - In BUSY, bus_req=1 and all bus_* outputs are stable.
  - stall = 1 in BUSY unless bus_ack=1 or a timeout fires this cycle.
  - Minimum total stall is 1 cycle (ack in the first BUSY cycle).
- Timeout counter:
  - Counter = 1 in the first BUSY cycle and increments each BUSY cycle.
  - When cnt==TIMEOUT && !bus_ack, the access completes with exc_bus=1, out_rdata=0. bus_req is therefore high for exactly TIMEOUT cycles.
  - If ack and timeout coincide, ack wins and the access completes normally.
- Completion edge:
  - At the ack edge the state returns to IDLE, all bus_* clear to 0 and the counter resets.
  - In the next cycle, out_valid=1 for exactly one cycle.
  - Loads: out_rdata = lane extracted from bus_rdata at offset addr, sign-extended (LB/LH/LW) or zero-extended (LBU/LHU) to DATA_W. LD passes through.
  - Stores: out_rdata=0.
- Back-to-back: a new accept is legal in the cycle out_valid is high, since state is IDLE.
- bus_ack while bus_req=0 is ignored.

Decomposition:
- mem_pkg: op codes, state encodings, NB/offset width helpers, size-decode function (op -> bytes, is_load, is_signed).
- One combinational sub-module, mem_lane_align: store replication plus byteen generation, and load lane extract plus extension, parametrised by DATA_W. The FSM, counter and registers stay in m_mem_access_unit.

Test Plan:
- DATA_W=32, SB addr 0x1003 wdata 0x000000AB, ack in 3rd BUSY cycle -> bus_addr 0x1000, bus_byteen 1000, bus_wdata 0xABABABAB, stall high 3 cycles, out_valid one cycle later, no exc.
- LH addr 0x1002, bus_rdata 0x80017FFF, ack first cycle -> out_rdata 0xFFFF8001; repeat with LHU -> 0x00008001; stall high 1 cycle each.
- LW addr 0x1001 -> bus_req never rises, stall 0, next cycle out_valid=1 exc_adel=1 out_rdata=0. SH addr 0x1001 -> exc_ades=1.
- TIMEOUT=4, SW with no ack -> bus_req high exactly 4 cycles, then out_valid=1 exc_bus=1. Separate case: ack in the 4th cycle -> normal completion, exc_bus=0.
- Reset asserted in 2nd BUSY cycle -> next cycle bus_req=0, stall=0, all outputs 0, no out_valid. A following LW at 0x2000 completes normally.
- DATA_W=64:
  - SD addr 0x8 -> byteen 0xFF, bus_addr 0x8.
  - LB addr 0xF with rdata byte7=0x80 -> out_rdata 0xFFFFFFFFFFFFFF80.
  - LD addr 0x4 -> exc_adel.
